// File: rtl/dm_pkg.sv
// Shared debug-module types: DMI request/response structs, DTM op and response codes.
package dm;

  typedef enum logic [1:0] {
    NOP   = 2'h0,
    READ  = 2'h1,
    WRITE = 2'h2
  } dtm_op_e;

  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

endpackage

// File: rtl/dmi_responder.sv
// DMI request responder: bridges DMI requests onto a simple register bus and
// returns one response per accepted request, with a bounded wait for the bus.
module dmi_responder
  import dm::*;
#(
  parameter int unsigned TimeoutCycles = 255,
  parameter logic [6:0]  MaxAddr       = 7'h5F
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dmi_clear_i,
  input  dmi_req_t    dmi_req_i,
  input  logic        dmi_req_valid_i,
  output logic        dmi_req_ready_o,
  output dmi_resp_t   dmi_resp_o,
  output logic        dmi_resp_valid_o,
  input  logic        dmi_resp_ready_i,
  output logic        reg_valid_o,
  output logic        reg_we_o,
  output logic [6:0]  reg_addr_o,
  output logic [31:0] reg_wdata_o,
  input  logic        reg_ready_i,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_err_i
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic [6:0]        addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  dmi_resp_t         resp_q, resp_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept, bus_op, timeout;

  assign dmi_req_ready_o  = (state_q == IDLE);
  assign dmi_resp_valid_o = (state_q == RESP);
  assign reg_valid_o      = (state_q == ACCESS);
  assign dmi_resp_o       = resp_q;
  assign reg_addr_o       = addr_q;
  assign reg_wdata_o      = wdata_q;
  assign reg_we_o         = we_q;

  assign accept  = dmi_req_valid_i & dmi_req_ready_o;
  assign bus_op  = ((dmi_req_i.op == READ) || (dmi_req_i.op == WRITE)) &&
                   (dmi_req_i.addr <= MaxAddr);
  // Fires on the last allowed wait cycle so reg_valid_o stays up exactly TimeoutCycles cycles.
  assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus_op) begin
            state_d = ACCESS;
            addr_d  = dmi_req_i.addr;
            wdata_d = dmi_req_i.data;
            we_d    = (dmi_req_i.op == WRITE);
            cnt_d   = '0;
          end else begin
            state_d     = RESP;
            resp_d.data = '0;
            resp_d.resp = (dmi_req_i.op == NOP) ? DTM_SUCCESS : DTM_ERR;
          end
        end
      end
      ACCESS: begin
        if (reg_ready_i) begin
          state_d = RESP;
          if (reg_err_i) begin
            resp_d.data = '0;
            resp_d.resp = DTM_ERR;
          end else begin
            resp_d.data = we_q ? 32'h0 : reg_rdata_i;
            resp_d.resp = DTM_SUCCESS;
          end
        end else if (timeout) begin
          state_d     = RESP;
          resp_d.data = '0;
          resp_d.resp = DTM_ERR;
        end
        if (!reg_ready_i && (cnt_q != CntW'(TimeoutCycles))) cnt_d = cnt_q + 1'b1;
      end
      RESP: begin
        if (dmi_resp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (dmi_clear_i) begin
      state_d = IDLE;
      resp_d  = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      resp_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      resp_q  <= resp_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_dmi_responder.sv
// Directed bench for dmi_responder (TimeoutCycles=4).
module tb_dmi_responder;
  import dm::*;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        dmi_clear_i;
  dmi_req_t    dmi_req_i;
  logic        dmi_req_valid_i;
  logic        dmi_req_ready_o;
  dmi_resp_t   dmi_resp_o;
  logic        dmi_resp_valid_o;
  logic        dmi_resp_ready_i;
  logic        reg_valid_o;
  logic        reg_we_o;
  logic [6:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic        reg_ready_i;
  logic [31:0] reg_rdata_i;
  logic        reg_err_i;

  int errs = 0;
  int checks = 0;
  int n;

  dmi_responder #(.TimeoutCycles(4), .MaxAddr(7'h5F)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmi_clear_i(dmi_clear_i),
    .dmi_req_i(dmi_req_i), .dmi_req_valid_i(dmi_req_valid_i), .dmi_req_ready_o(dmi_req_ready_o),
    .dmi_resp_o(dmi_resp_o), .dmi_resp_valid_o(dmi_resp_valid_o), .dmi_resp_ready_i(dmi_resp_ready_i),
    .reg_valid_o(reg_valid_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o),
    .reg_ready_i(reg_ready_i), .reg_rdata_i(reg_rdata_i), .reg_err_i(reg_err_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [63:0] rsp(input logic [31:0] d, input logic [1:0] r);
    return {30'h0, d, r};
  endfunction

  task automatic send(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d);
    dmi_req_i.addr  = a;
    dmi_req_i.op    = dtm_op_e'(op);
    dmi_req_i.data  = d;
    dmi_req_valid_i = 1'b1;
    cyc();
    dmi_req_valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    dmi_resp_ready_i = 1'b1;
    cyc();
    dmi_resp_ready_i = 1'b0;
    chk({tag, "_idle"}, {62'h0, dmi_resp_valid_o, dmi_req_ready_o}, 64'h1);
  endtask

  initial begin
    rst_ni = 1'b0; dmi_clear_i = 1'b0; dmi_req_i = '0; dmi_req_valid_i = 1'b0;
    dmi_resp_ready_i = 1'b0; reg_ready_i = 1'b0; reg_rdata_i = '0; reg_err_i = 1'b0;
    #3;
    chk("rst_ctl", {61'h0, dmi_req_ready_o, dmi_resp_valid_o, reg_valid_o}, 64'h4);
    chk("rst_bus", {24'h0, reg_we_o, reg_addr_o, reg_wdata_o}, 64'h0);
    chk("rst_resp", {30'h0, dmi_resp_o}, 64'h0);
    #9 rst_ni = 1'b1;
    cyc();

    // READ 0x11, bus ready on the third access cycle
    send(7'h11, 2'd1, 32'h0);
    chk("rd_access", {55'h0, reg_valid_o, reg_we_o, reg_addr_o}, {55'h0, 2'b10, 7'h11});
    chk("rd_reqrdy", {63'h0, dmi_req_ready_o}, 64'h0);
    cyc();
    chk("rd_hold", {55'h0, reg_valid_o, reg_we_o, reg_addr_o}, {55'h0, 2'b10, 7'h11});
    cyc();
    reg_ready_i = 1'b1; reg_rdata_i = 32'hDEADBEEF;
    cyc();
    reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
    chk("rd_valid", {62'h0, dmi_resp_valid_o, reg_valid_o}, 64'h2);
    chk("rd_resp", {30'h0, dmi_resp_o}, rsp(32'hDEADBEEF, DTM_SUCCESS));
    cyc();
    chk("rd_resp_hold", {29'h0, dmi_resp_valid_o, dmi_resp_o}, {29'h0, 1'b1, 32'hDEADBEEF, DTM_SUCCESS});
    drain("rd");

    // WRITE 0x10, ready alongside the first reg_valid cycle
    send(7'h10, 2'd2, 32'h1);
    chk("wr_bus", {23'h0, reg_valid_o, reg_we_o, reg_addr_o, reg_wdata_o}, {23'h0, 2'b11, 7'h10, 32'h1});
    reg_ready_i = 1'b1; reg_rdata_i = 32'hFFFFFFFF;
    cyc();
    reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
    chk("wr_resp", {29'h0, dmi_resp_valid_o, dmi_resp_o}, {29'h0, 1'b1, 32'h0, DTM_SUCCESS});
    drain("wr");

    // Out-of-range address, reserved op, NOP: straight to RESP
    send(7'h70, 2'd1, 32'h0);
    chk("oor_resp", {28'h0, reg_valid_o, dmi_resp_valid_o, dmi_resp_o}, {28'h0, 2'b01, 32'h0, DTM_ERR});
    drain("oor");
    send(7'h11, 2'd3, 32'h0);
    chk("rsv_resp", {28'h0, reg_valid_o, dmi_resp_valid_o, dmi_resp_o}, {28'h0, 2'b01, 32'h0, DTM_ERR});
    drain("rsv");
    send(7'h05, 2'd0, 32'h0);
    chk("nop_resp", {28'h0, reg_valid_o, dmi_resp_valid_o, dmi_resp_o}, {28'h0, 2'b01, 32'h0, DTM_SUCCESS});
    drain("nop");

    // MaxAddr itself goes to the bus; bus error becomes ERR
    send(7'h5F, 2'd1, 32'h0);
    chk("max_access", {56'h0, reg_valid_o, reg_addr_o}, {56'h0, 1'b1, 7'h5F});
    reg_ready_i = 1'b1; reg_err_i = 1'b1; reg_rdata_i = 32'h55AA55AA;
    cyc();
    reg_ready_i = 1'b0; reg_err_i = 1'b0; reg_rdata_i = 32'h0;
    chk("err_resp", {30'h0, dmi_resp_o}, rsp(32'h0, DTM_ERR));
    drain("err");

    // Timeout with ready held low
    send(7'h01, 2'd1, 32'h0);
    n = 0;
    while (reg_valid_o && n < 20) begin
      n++;
      cyc();
    end
    chk("to_cycles", 64'(n), 64'd4);
    chk("to_resp", {29'h0, dmi_resp_valid_o, dmi_resp_o}, {29'h0, 1'b1, 32'h0, DTM_ERR});
    drain("to");

    // Ready coincident with the timeout cycle wins
    send(7'h02, 2'd1, 32'h0);
    cyc(); cyc(); cyc();
    chk("toc_still", {63'h0, reg_valid_o}, 64'h1);
    reg_ready_i = 1'b1; reg_rdata_i = 32'h12345678;
    cyc();
    reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
    chk("toc_resp", {29'h0, dmi_resp_valid_o, dmi_resp_o}, {29'h0, 1'b1, 32'h12345678, DTM_SUCCESS});
    drain("toc");

    // Clear mid-ACCESS overrides a simultaneous ready
    send(7'h11, 2'd1, 32'h0);
    dmi_clear_i = 1'b1; reg_ready_i = 1'b1; reg_rdata_i = 32'h0BADF00D;
    cyc();
    dmi_clear_i = 1'b0; reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
    chk("clr_acc", {61'h0, reg_valid_o, dmi_resp_valid_o, dmi_req_ready_o}, 64'h1);
    cyc();
    chk("clr_acc_quiet", {62'h0, reg_valid_o, dmi_resp_valid_o}, 64'h0);

    // Clear while a response is pending and not taken
    send(7'h00, 2'd0, 32'h0);
    chk("clr_rsp_pre", {63'h0, dmi_resp_valid_o}, 64'h1);
    dmi_clear_i = 1'b1;
    cyc();
    dmi_clear_i = 1'b0;
    chk("clr_rsp", {62'h0, dmi_resp_valid_o, dmi_req_ready_o}, 64'h1);

    send(7'h11, 2'd1, 32'h0);
    reg_ready_i = 1'b1; reg_rdata_i = 32'hCAFEF00D;
    cyc();
    reg_ready_i = 1'b0; reg_rdata_i = 32'h0;
    chk("post_clr_rd", {29'h0, dmi_resp_valid_o, dmi_resp_o}, {29'h0, 1'b1, 32'hCAFEF00D, DTM_SUCCESS});
    drain("post_clr");

    // Reset mid-ACCESS acts without a clock edge
    send(7'h22, 2'd2, 32'hA5A5A5A5);
    chk("rst_pre", {23'h0, reg_valid_o, reg_we_o, reg_addr_o, reg_wdata_o}, {23'h0, 2'b11, 7'h22, 32'hA5A5A5A5});
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_ctl", {61'h0, dmi_req_ready_o, dmi_resp_valid_o, reg_valid_o}, 64'h4);
    chk("arst_bus", {24'h0, reg_we_o, reg_addr_o, reg_wdata_o}, 64'h0);
    chk("arst_resp", {30'h0, dmi_resp_o}, 64'h0);
    reg_ready_i = 1'b1;
    #2 rst_ni = 1'b1;
    cyc();
    reg_ready_i = 1'b0;
    chk("arst_after", {61'h0, dmi_req_ready_o, dmi_resp_valid_o, reg_valid_o}, 64'h4);
    cyc();
    chk("arst_quiet", {63'h0, dmi_resp_valid_o}, 64'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/dmi_responder.md
DMI_RESPONDER -- requirements
Module: dmi_responder

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 255, meaning the maximum number of cycles to wait for reg_ready_i (range 1..65535).
REQ-002 SHALL have parameter MaxAddr, default 7'h5F, meaning the highest DMI address forwarded to the register bus.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port dmi_clear_i, input, 1 bit: synchronous abort of any in-flight transaction.
REQ-006 SHALL have ports dmi_req_i (input, dm::dmi_req_t), dmi_req_valid_i (input, 1) and dmi_req_ready_o (output, 1): the request channel.
REQ-007 SHALL have ports dmi_resp_o (output, dm::dmi_resp_t), dmi_resp_valid_o (output, 1) and dmi_resp_ready_i (input, 1): the response channel.
REQ-008 SHALL have register-bus outputs reg_valid_o (1), reg_we_o (1), reg_addr_o (7) and reg_wdata_o (32).
REQ-009 SHALL have register-bus inputs reg_ready_i (1), reg_rdata_i (32) and reg_err_i (1).

Function
REQ-010 SHALL implement a three-state FSM with states IDLE, ACCESS and RESP.
REQ-011 SHALL drive dmi_req_ready_o = 1 only in IDLE; a request is accepted on valid&ready.
REQ-012 SHALL, on accept of READ/WRITE with addr<=MaxAddr, register addr, data and we (op==WRITE) and enter ACCESS; reg_valid_o is asserted the next cycle (1-cycle latency).
REQ-013 SHALL hold reg_valid_o, reg_addr_o, reg_we_o and reg_wdata_o stable in ACCESS until a cycle with reg_ready_i=1, or until abort/timeout.
REQ-014 SHALL, on reg_ready_i in ACCESS, enter RESP: read -> data=reg_rdata_i and resp=DTM_SUCCESS; write -> data=0 and resp=DTM_SUCCESS; reg_err_i=1 -> data=0 and resp=DTM_ERR.
REQ-015 SHALL assert dmi_resp_valid_o exactly in RESP, i.e. the cycle after the reg_ready_i handshake.
REQ-016 SHALL, on accept of NOP, go directly IDLE->RESP with data=0 and resp=DTM_SUCCESS; no bus access.
REQ-017 SHALL, on accept of op 2'b11 (reserved) or addr>MaxAddr, go directly IDLE->RESP with data=0 and resp=DTM_ERR; no bus access.
REQ-018 SHALL hold dmi_resp_o stable in RESP until dmi_resp_ready_i=1, then return to IDLE; the next request can be accepted no earlier than the following cycle.
REQ-019 SHALL run a timeout counter, cleared on entry to ACCESS and incremented each ACCESS cycle without reg_ready_i, width $clog2(TimeoutCycles+1), saturating (never wrapping).
REQ-020 SHALL, when the counter reaches TimeoutCycles, deassert reg_valid_o and enter RESP with data=0 and resp=DTM_ERR.
REQ-021 SHALL give reg_ready_i priority over timeout when both occur in the same cycle.
REQ-022 SHALL, on dmi_clear_i=1 in any state, go to IDLE next cycle, deassert reg_valid_o and dmi_resp_valid_o, and discard the pending response.
REQ-023 SHALL let dmi_clear_i take priority over request accept, reg_ready_i, timeout and response handshake occurring in the same cycle.
REQ-024 SHALL drive reg_valid_o=0 whenever not in ACCESS, with ignored reg_ready_i outside ACCESS.

Reset
REQ-025 SHALL, while rst_ni=0, immediately set state=IDLE, dmi_req_ready_o=1, dmi_resp_valid_o=0, dmi_resp_o='0, reg_valid_o=0, reg_we_o=0, reg_addr_o=0, reg_wdata_o=0 and counter=0.
REQ-026 SHALL, on reset assertion mid-ACCESS or mid-RESP, abandon the transaction with no response produced after release.

Structure
REQ-027 SHALL take dmi_req_t, dmi_resp_t, dtm_op_e (NOP/READ/WRITE) and the response codes DTM_SUCCESS=0, DTM_ERR=2, DTM_BUSY=3 from package dm; no new package types are added.
REQ-028 SHALL be a single flat module; no sub-module instantiations.

Verification
REQ-029 SHALL cover READ addr 0x11 with reg_ready_i after 3 cycles and rdata 0xDEADBEEF -> resp {0xDEADBEEF, SUCCESS}, resp_valid 1 cycle after ready.
REQ-030 SHALL cover WRITE addr 0x10 data 0x1 with ready same cycle as reg_valid_o -> reg_we_o=1, reg_wdata_o=0x1, resp {0, SUCCESS}.
REQ-031 SHALL cover READ addr 0x70, and separately op 2'b11 -> reg_valid_o never asserted, resp {0, ERR} one cycle after accept.
REQ-032 SHALL cover TimeoutCycles=4 with reg_ready_i held 0 -> reg_valid_o high exactly 4 cycles, then resp ERR; also ready coincident with timeout -> SUCCESS.
REQ-033 SHALL cover dmi_clear_i pulsed mid-ACCESS, and again with resp_valid and dmi_resp_ready_i=0 -> IDLE next cycle, no response emitted, next READ completes normally.
REQ-034 SHALL cover rst_ni asserted mid-ACCESS -> all outputs at reset values immediately, without waiting for a clock edge.
